// File: rtl/lcd_frame_sequencer_if.sv
// Signal bundle between the pixel timing / pattern path and the LCD frame sequencer.
interface lcd_frame_sequencer_if;
  logic       vsync_in;
  logic       enable_req;
  logic       step_req;
  logic       blank_out;
  logic       bl_en;
  logic [2:0] pattern_sel;
  logic       frame_tick;
  logic [2:0] state_out;
  logic       fault;

  modport master (
    output vsync_in, enable_req, step_req,
    input  blank_out, bl_en, pattern_sel, frame_tick, state_out, fault
  );

  modport slave (
    input  vsync_in, enable_req, step_req,
    output blank_out, bl_en, pattern_sel, frame_tick, state_out, fault
  );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// LCD frame sequencer: panel power-up/down blanking, backlight enable and
// test-pattern scheduling, with every visible change aligned to a frame tick.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OFF      | panel blanked, backlight off, waiting for enable at a tick
// WARMUP   | blanked for WARM_FRAMES ticks before showing video
// ON       | video shown, pattern auto-advances / manual steps
// COOLDOWN | backlight off, blank from next tick, OFF after COOL_FRAMES
// FAULT    | vsync lost; blanked until enable_req drops
module lcd_frame_sequencer #(
  parameter int VS_POL      = 0,
  parameter int WARM_FRAMES = 4,
  parameter int COOL_FRAMES = 2,
  parameter int HOLD_FRAMES = 120,
  parameter int NUM_PAT     = 8,
  parameter int VS_TIMEOUT  = 2000000
) (
  input logic                  PixelClk,
  input logic                  nRST,
  lcd_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WARMUP   = 3'd1,
    S_ON       = 3'd2,
    S_COOLDOWN = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam int              WD_W     = $clog2(VS_TIMEOUT + 1);
  localparam logic            VS_ACT   = (VS_POL != 0);
  localparam logic [7:0]      WARM_LIM = 8'(WARM_FRAMES);
  localparam logic [7:0]      COOL_LIM = 8'(COOL_FRAMES);
  localparam logic [15:0]     HOLD_LIM = 16'(HOLD_FRAMES);
  localparam logic [2:0]      PAT_LAST = 3'(NUM_PAT - 1);
  localparam logic [WD_W-1:0] WD_LIM   = WD_W'(VS_TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  state_t          state_q, state_n;
  logic            vs_d, tick_q, tick_c;
  logic [7:0]      frm_q, frm_n, frm_inc;
  logic [15:0]     hold_q, hold_n, hold_inc;
  logic [WD_W-1:0] wd_q, wd_n, wd_inc;
  logic            pend_q, pend_n;
  logic [2:0]      pat_q, pat_n, pat_adv;
  logic            blank_q, blank_n, bl_q, bl_n, fault_q, fault_n;
  logic            active, wd_expire;

  // Leading edge of the active sync level marks the frame start.
  assign tick_c    = (bus.vsync_in == VS_ACT) && (vs_d != VS_ACT);

  // Counters saturate rather than wrap.
  assign frm_inc   = (frm_q == '1) ? frm_q : frm_q + 8'd1;
  assign hold_inc  = (hold_q == '1) ? hold_q : hold_q + 16'd1;
  assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + WD_ONE;
  assign pat_adv   = (pat_q == PAT_LAST) ? 3'd0 : pat_q + 3'd1;

  // wd_q holds the number of cycles elapsed since the last tick, so the fault
  // lands exactly VS_TIMEOUT cycles after the last frame_tick.
  assign active    = (state_q == S_WARMUP) || (state_q == S_ON) || (state_q == S_COOLDOWN);
  assign wd_expire = active && !tick_q && (wd_inc >= WD_LIM);

  // Next-state and next-output decode.
  always_comb begin
    state_n = state_q;
    frm_n   = frm_q;
    hold_n  = hold_q;
    wd_n    = '0;
    pend_n  = 1'b0;
    pat_n   = pat_q;
    blank_n = blank_q;
    bl_n    = bl_q;
    fault_n = fault_q;
    case (state_q)
      S_OFF: begin
        blank_n = 1'b1;
        bl_n    = 1'b0;
        fault_n = 1'b0;
        if (tick_q && bus.enable_req) begin
          state_n = S_WARMUP;
          frm_n   = '0;
          pat_n   = 3'd0;
          wd_n    = WD_ONE;
        end
      end
      S_WARMUP: begin
        wd_n = tick_q ? WD_ONE : wd_inc;
        if (!bus.enable_req) begin
          state_n = S_OFF;
          wd_n    = '0;
        end else if (tick_q) begin
          frm_n = frm_inc;
          if (frm_inc == WARM_LIM) begin
            state_n = S_ON;
            blank_n = 1'b0;
            bl_n    = 1'b1;
            hold_n  = '0;
          end
        end
      end
      S_ON: begin
        wd_n   = tick_q ? WD_ONE : wd_inc;
        pend_n = pend_q | bus.step_req;
        if (!bus.enable_req) begin
          state_n = S_COOLDOWN;
          bl_n    = 1'b0;
          frm_n   = '0;
          pend_n  = 1'b0;
        end else if (tick_q) begin
          // A step seen on the tick cycle itself waits for the next tick.
          pend_n = bus.step_req;
          if (pend_q || (hold_inc >= HOLD_LIM)) begin
            pat_n  = pat_adv;
            hold_n = '0;
          end else begin
            hold_n = hold_inc;
          end
        end
      end
      S_COOLDOWN: begin
        wd_n = tick_q ? WD_ONE : wd_inc;
        bl_n = 1'b0;
        if (tick_q) begin
          frm_n   = frm_inc;
          blank_n = 1'b1;
          if (frm_inc == COOL_LIM) begin
            state_n = S_OFF;
            wd_n    = '0;
          end
        end
      end
      S_FAULT: begin
        blank_n = 1'b1;
        bl_n    = 1'b0;
        fault_n = 1'b1;
        if (!bus.enable_req) begin
          state_n = S_OFF;
          fault_n = 1'b0;
        end
      end
      default: begin
        state_n = S_OFF;
        blank_n = 1'b1;
        bl_n    = 1'b0;
        fault_n = 1'b0;
      end
    endcase
    if (wd_expire) begin
      state_n = S_FAULT;
      blank_n = 1'b1;
      bl_n    = 1'b0;
      fault_n = 1'b1;
      wd_n    = '0;
      pend_n  = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_OFF;
      vs_d    <= !VS_ACT;
      tick_q  <= 1'b0;
      frm_q   <= '0;
      hold_q  <= '0;
      wd_q    <= '0;
      pend_q  <= 1'b0;
      pat_q   <= 3'd0;
      blank_q <= 1'b1;
      bl_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      vs_d    <= bus.vsync_in;
      tick_q  <= tick_c;
      frm_q   <= frm_n;
      hold_q  <= hold_n;
      wd_q    <= wd_n;
      pend_q  <= pend_n;
      pat_q   <= pat_n;
      blank_q <= blank_n;
      bl_q    <= bl_n;
      fault_q <= fault_n;
    end
  end

  assign bus.state_out   = state_q;
  assign bus.frame_tick  = tick_q;
  assign bus.pattern_sel = pat_q;
  assign bus.blank_out   = blank_q;
  assign bus.bl_en       = bl_q;
  assign bus.fault       = fault_q;

endmodule
